// File: rtl/mux_1b_16.sv
// 16-bit two-way word mux with a registered shadow copy (word, select, change strobe).
// Define MUX1B16_PARITY_EN to add the combinational even-parity output of Out.
module mux_1b_16 (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        OP,
    output logic [15:0] Out,
    output logic [15:0] OutQ,
    output logic        SelQ,
    output logic        Changed
`ifdef MUX1B16_PARITY_EN
    ,
    output logic        Parity
`endif
);

    localparam int WIDTH = 16;

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             sel_q;
    logic             sel_d;
    logic             changed_q;
    logic             changed_d;

    // Ternary keeps bits where A and B agree when OP is unknown, others go X.
    assign Out = OP ? B : A;

    always_comb begin
        out_d     = Out;
        sel_d     = OP;
        changed_d = (Out != out_q);
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            out_q     <= '0;
            sel_q     <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            sel_q     <= sel_d;
            changed_q <= changed_d;
        end
    end

    assign OutQ    = out_q;
    assign SelQ    = sel_q;
    assign Changed = changed_q;

`ifdef MUX1B16_PARITY_EN
    assign Parity = ^Out;
`endif

endmodule

// File: tb/tb_mux_1b_16.sv
// Self-checking bench for mux_1b_16: directed scenarios plus randomized traffic
// compared against a behavioural model of the select and shadow register.
module tb_mux_1b_16;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [15:0] A;
    logic [15:0] B;
    logic        OP;
    wire  [15:0] Out;
    wire  [15:0] OutQ;
    wire         SelQ;
    wire         Changed;
`ifdef MUX1B16_PARITY_EN
    wire         Parity;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] m_outq;
    logic        m_selq;
    logic        m_changed;

    mux_1b_16 dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .A       (A),
        .B       (B),
        .OP      (OP),
        .Out     (Out),
        .OutQ    (OutQ),
        .SelQ    (SelQ),
        .Changed (Changed)
`ifdef MUX1B16_PARITY_EN
        ,
        .Parity  (Parity)
`endif
    );

    always #5 CLK = ~CLK;

    // Reference: the word the select points at.
    function automatic logic [15:0] ref_sel(input logic [15:0] a, input logic [15:0] b,
                                            input logic op);
        if (op == 1'b0) return a;
        return b;
    endfunction

    // Reference parity: 1 when the number of set bits is odd.
    function automatic logic ref_parity(input logic [15:0] w);
        int ones = 0;
        for (int i = 0; i < 16; i++) if (w[i]) ones++;
        return (ones % 2) == 1;
    endfunction

    // Advance one rising edge, updating the shadow model from the inputs seen at the edge.
    task automatic tick();
        logic [15:0] sel;
        @(posedge CLK);
        sel = ref_sel(A, B, OP);
        if (Reset) begin
            m_outq    = 16'h0000;
            m_selq    = 1'b0;
            m_changed = 1'b0;
        end else begin
            m_changed = (sel != m_outq);
            m_outq    = sel;
            m_selq    = OP;
        end
        #1;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        Reset = 1'b1; A = 16'h1234; B = 16'h0000; OP = 1'b0;
        m_outq = 16'h0000; m_selq = 1'b0; m_changed = 1'b0;
        tick();
        tick();
        vectors++;
        if (OutQ !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_outq actual=%h required=0000", OutQ); end
        vectors++;
        if (SelQ !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_selq actual=%b required=0", SelQ); end
        vectors++;
        if (Changed !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_changed actual=%b required=0", Changed); end
        vectors++;
        if (Out !== 16'h1234) begin miscompares++; $display("[TB] FAIL reset_out actual=%h required=1234", Out); end
    endtask

    task automatic test_comb();
        A = 16'h0001; B = 16'h0000; OP = 1'b0;
        #10;
        vectors++;
        if (Out !== 16'h0001) begin miscompares++; $display("[TB] FAIL comb_a actual=%h required=0001", Out); end
        OP = 1'b1;
        #10;
        vectors++;
        if (Out !== 16'h0000) begin miscompares++; $display("[TB] FAIL comb_b actual=%h required=0000", Out); end
    endtask

    task automatic test_toggle();
        logic [15:0] req [3] = '{16'hFFFF, 16'h0000, 16'hFFFF};
        logic        ops [3] = '{1'b0, 1'b1, 1'b0};
        A = 16'hFFFF; B = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            OP = ops[i];
            #3;
            vectors++;
            if (Out !== req[i]) begin
                miscompares++;
                $display("[TB] FAIL toggle_%0d actual=%h required=%h", i, Out, req[i]);
            end
        end
    endtask

    task automatic test_reset_release();
        @(negedge CLK);
        A = 16'h1234; B = 16'h0000; OP = 1'b0;
        Reset = 1'b0;
        tick();
        vectors++;
        if (OutQ !== 16'h1234) begin miscompares++; $display("[TB] FAIL release_outq actual=%h required=1234", OutQ); end
        vectors++;
        if (Changed !== 1'b1) begin miscompares++; $display("[TB] FAIL release_changed actual=%b required=1", Changed); end
        tick();
        vectors++;
        if (Changed !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_changed actual=%b required=0", Changed); end
        vectors++;
        if (OutQ !== 16'h1234) begin miscompares++; $display("[TB] FAIL hold_outq actual=%h required=1234", OutQ); end
    endtask

    task automatic test_switch();
        @(negedge CLK);
        A = 16'h00AA; B = 16'h5500; OP = 1'b0;
        tick();
        @(negedge CLK);
        OP = 1'b1;
        #1;
        vectors++;
        if (Out !== 16'h5500) begin miscompares++; $display("[TB] FAIL switch_out actual=%h required=5500", Out); end
        vectors++;
        if (OutQ !== 16'h00AA || SelQ !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL switch_early actual=%h/%b required=00aa/0", OutQ, SelQ);
        end
        tick();
        vectors++;
        if (OutQ !== 16'h5500 || SelQ !== 1'b1 || Changed !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL switch_late actual=%h/%b/%b required=5500/1/1", OutQ, SelQ, Changed);
        end
    endtask

    task automatic test_random();
        logic [15:0] pool [4];
        for (int k = 0; k < 4; k++) pool[k] = 16'($urandom);
        for (int n = 0; n < 300; n++) begin
            @(negedge CLK);
            A  = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 3)] : 16'($urandom);
            B  = pool[$urandom_range(0, 3)];
            OP = 1'($urandom_range(0, 1));
            #1;
            vectors++;
            if (Out !== ref_sel(A, B, OP)) begin
                miscompares++;
                $display("[TB] FAIL rand_out n=%0d actual=%h required=%h", n, Out, ref_sel(A, B, OP));
            end
            if ($urandom_range(0, 19) == 0) begin
                Reset = 1'b1;
                m_outq = 16'h0000; m_selq = 1'b0; m_changed = 1'b0;
                #1;
                vectors++;
                if (OutQ !== 16'h0000 || SelQ !== 1'b0 || Changed !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL rand_async_reset n=%0d actual=%h/%b/%b required=0000/0/0", n, OutQ, SelQ, Changed);
                end
                Reset = 1'b0;
            end
            tick();
            vectors++;
            if (OutQ !== m_outq || SelQ !== m_selq || Changed !== m_changed) begin
                miscompares++;
                $display("[TB] FAIL rand_regs n=%0d actual=%h/%b/%b required=%h/%b/%b",
                         n, OutQ, SelQ, Changed, m_outq, m_selq, m_changed);
            end
        end
    endtask

`ifdef MUX1B16_PARITY_EN
    task automatic test_parity();
        A = 16'h0007; OP = 1'b0;
        #1;
        vectors++;
        if (Parity !== ref_parity(Out) || Parity !== 1'b1) begin
            miscompares++; $display("[TB] FAIL parity_a actual=%b required=1", Parity);
        end
        B = 16'h000F; OP = 1'b1;
        #1;
        vectors++;
        if (Parity !== 1'b0) begin miscompares++; $display("[TB] FAIL parity_b actual=%b required=0", Parity); end
        for (int n = 0; n < 50; n++) begin
            A = 16'($urandom); B = 16'($urandom); OP = 1'($urandom_range(0, 1));
            #1;
            vectors++;
            if (Parity !== ref_parity(ref_sel(A, B, OP))) begin
                miscompares++;
                $display("[TB] FAIL parity_rand n=%0d actual=%b required=%b", n, Parity, ref_parity(ref_sel(A, B, OP)));
            end
        end
    endtask
`endif

    initial begin
        Reset = 1'b1; A = 16'h0000; B = 16'h0000; OP = 1'b0;
        test_reset();
        test_comb();
        test_toggle();
        test_reset_release();
        test_switch();
        test_random();
`ifdef MUX1B16_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mux_1b_16.md
# mux_1b_16

Two-input, 16-bit word multiplexer steered by a 1-bit select, used on the accumulator datapath to choose between two 16-bit operand sources. The primary output is purely combinational. A clocked shadow stage also provides a registered copy of the selected word, the registered select, and a change strobe for downstream sequential logic.

## Interface
- WIDTH, 16: data width of A, B, Out, OutQ; fixed at 16 for this block.
- CLK  input  1  rising-edge clock for the shadow stage only.
- Reset  input  1  asynchronous, active-high reset; clears all registered outputs.
- A  input  16  operand selected when OP = 0.
- B  input  16  operand selected when OP = 1.
- OP  input  1  select: 0 -> A, 1 -> B.
- Out  output  16  combinational selected word.
- OutQ  output  16  registered copy of Out.
- SelQ  output  1  registered copy of OP.
- Changed  output  1  one-cycle strobe: OutQ updated to a different value this cycle.
- Parity  output  1  even parity of Out; present only with MUX1B16_PARITY_EN.

## Operation
- Out = (OP == 0) ? A : B, on all 16 bits, with no clock involvement.
- Out is unaffected by CLK and Reset. It stays valid while Reset is asserted.
- If OP is X or Z, Out resolves per bit: bits where A and B agree pass through, and all other bits are X. No latch is inferred.
- Shadow stage, on each rising CLK edge with Reset low:
  - OutQ <= Out.
  - SelQ <= OP.
  - Changed <= (Out != OutQ).
- Reset high, at any time and independent of CLK: OutQ = 16'h0000, SelQ = 0, Changed = 0.
- Reset release: the first rising edge after deassertion loads normally. Changed is 1 on that edge if Out != 0.
- Data and select changing together: Out reflects the new A, B, or OP immediately. There is no priority between inputs.

## Timing
- Out: zero-cycle latency, combinational path from A, B, and OP.
- OutQ, SelQ: one-cycle latency. They capture the value present at the rising edge.
- Changed: asserted in the cycle after the edge at which OutQ takes a new value. It is high for exactly one cycle per update.
- Reset values: OutQ = 0, SelQ = 0, Changed = 0. Parity is combinational and is not reset.
- Reset mid-operation clears registered outputs within the same delta (asynchronous). Out keeps tracking the inputs.
- No handshake; inputs are sampled every cycle.

## Configuration
- MUX1B16_PARITY_EN defined:
  - The Parity output exists and equals the XOR-reduction of Out[15:0], combinational.
  - Example: Out = 16'h0001 gives Parity = 1; Out = 16'h0003 gives Parity = 0.
- MUX1B16_PARITY_EN undefined:
  - The Parity port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- A = 1, B = 0, OP = 0, wait 10 time units -> Out = 1 (equals A).
- From the previous state, OP = 1, wait 10 -> Out = 0 (equals B), with no clock edge required.
- A = 16'hFFFF, B = 16'h0000, toggle OP 0 -> 1 -> 0 -> Out = FFFF, 0000, FFFF. Every bit is checked.
- Reset = 1 with clock running, A = 16'h1234, OP = 0:
  - While in reset: OutQ = 0, SelQ = 0, Changed = 0, and Out = 16'h1234.
  - After deassertion, first edge: OutQ = 16'h1234, Changed = 1.
  - Next edge with the same inputs: Changed = 0.
- A = 16'h00AA, B = 16'h5500, OP switched 0 -> 1 between edges:
  - Out changes immediately.
  - OutQ = 16'h5500 and SelQ = 1 only after the next edge.
- With MUX1B16_PARITY_EN: A = 16'h0007, OP = 0 -> Parity = 1; then B = 16'h000F, OP = 1 -> Parity = 0.
